// File: rtl/imem_boot_loader.sv
// Streams program words into instruction memory over valid/ready, then holds
// the CPU in reset for a few idle cycles before releasing it.
module imem_boot_loader #(
  parameter int DEPTH       = 32,
  parameter int DATA_W      = 32,
  parameter int HOLD_CYCLES = 2,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic              ld_last_i,
  output logic              im_we_o,
  output logic [31:0]       im_addr_o,
  output logic [DATA_W-1:0] im_wdata_o,
  output logic              cpu_rst_o,
  output logic              done_o,
  output logic              err_o,
  output logic [CW-1:0]     word_cnt_o
);

  localparam int HOLD_W = 4;

  typedef enum logic [1:0] {S_LOAD, S_HOLD, S_RUN, S_ERR} state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CW-1:0]       count_q, count_d;
  logic                we_q, we_d;
  logic [31:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic xfer;
  logic room;
  logic hold_expired;

  assign xfer         = ld_valid_i && (state_q == S_LOAD);
  assign room         = count_q < CW'(DEPTH);
  assign hold_expired = hold_q == HOLD_W'(HOLD_CYCLES);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_LOAD;
      hold_q    <= '0;
      count_q   <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      count_q   <= count_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Release happens on the edge after the hold counter has reached its target,
  // so cpu_rst_o rises HOLD_CYCLES+1 edges after the last word is accepted.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      S_LOAD: begin
        if (xfer) begin
          if (!room) begin
            state_d = S_ERR;
          end else if (ld_last_i) begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (hold_expired) begin
          state_d = S_RUN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    count_d   = count_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    err_d     = err_q;
    case (state_q)
      S_LOAD: begin
        if (xfer && room) begin
          we_d    = 1'b1;
          addr_d  = {{(32 - CW - 2){1'b0}}, count_q, 2'b00};
          wdata_d = ld_data_i;
          count_d = count_q + 1'b1;
        end else if (xfer) begin
          err_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (hold_expired) begin
          cpu_rst_d = 1'b1;
          done_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign ld_ready_o = (state_q == S_LOAD);
  assign im_we_o    = we_q;
  assign im_addr_o  = addr_q;
  assign im_wdata_o = wdata_q;
  assign cpu_rst_o  = cpu_rst_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign word_cnt_o = count_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: a timeline model of the load sequence is
// compared against the DUT every cycle, plus literal checks per scenario.
module tb_imem_boot_loader;

  localparam int DEPTH  = 32;
  localparam int DATA_W = 32;
  localparam int HOLD   = 2;
  localparam int CW     = $clog2(DEPTH + 1);

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              ld_valid_i = 1'b0;
  logic              ld_ready_o;
  logic [DATA_W-1:0] ld_data_i = '0;
  logic              ld_last_i = 1'b0;
  logic              im_we_o;
  logic [31:0]       im_addr_o;
  logic [DATA_W-1:0] im_wdata_o;
  logic              cpu_rst_o;
  logic              done_o;
  logic              err_o;
  logic [CW-1:0]     word_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  imem_boot_loader #(.DEPTH(DEPTH), .DATA_W(DATA_W), .HOLD_CYCLES(HOLD)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .ld_valid_i (ld_valid_i),
    .ld_ready_o (ld_ready_o),
    .ld_data_i  (ld_data_i),
    .ld_last_i  (ld_last_i),
    .im_we_o    (im_we_o),
    .im_addr_o  (im_addr_o),
    .im_wdata_o (im_wdata_o),
    .cpu_rst_o  (cpu_rst_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .word_cnt_o (word_cnt_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: words accepted so far, the edge on which "last" was taken,
  // and whether an overflow occurred. Everything else follows from those.
  int          edge_cnt;
  int          m_n;
  int          m_last_edge;
  bit          m_err;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  logic        m_ready;
  logic        m_run;

  assign m_ready = (m_last_edge < 0) && !m_err;
  assign m_run   = (m_last_edge >= 0) && (edge_cnt >= m_last_edge + 1 + HOLD);

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      edge_cnt    <= 0;
      m_n         <= 0;
      m_last_edge <= -1;
      m_err       <= 1'b0;
      m_we        <= 1'b0;
      m_addr      <= '0;
      m_data      <= '0;
    end else begin
      edge_cnt <= edge_cnt + 1;
      m_we     <= 1'b0;
      if (ld_valid_i && m_ready) begin
        if (m_n < DEPTH) begin
          m_we   <= 1'b1;
          m_addr <= 32'(m_n * 4);
          m_data <= ld_data_i;
          m_n    <= m_n + 1;
          if (ld_last_i) m_last_edge <= edge_cnt + 1;
        end else begin
          m_err <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk_i) begin
    chk("ready",   ld_ready_o, m_ready);
    chk("we",      im_we_o, m_we);
    chk("addr",    im_addr_o, m_addr);
    chk("wdata",   im_wdata_o, m_data);
    chk("cpu_rst", cpu_rst_o, m_run);
    chk("done",    done_o, m_run);
    chk("err",     err_o, m_err);
    chk("cnt",     word_cnt_o, 64'(m_n));
  end

  logic [63:0] wlog[$];
  always @(negedge clk_i) begin
    if (rst_i && im_we_o) wlog.push_back({im_addr_o, im_wdata_o});
  end

  task automatic do_reset();
    #2;
    rst_i      = 1'b0;
    ld_valid_i = 1'b0;
    ld_last_i  = 1'b0;
    #1;
    chk("rst_ready",   ld_ready_o, 1);
    chk("rst_we",      im_we_o, 0);
    chk("rst_cpu_rst", cpu_rst_o, 0);
    chk("rst_cnt",     word_cnt_o, 0);
    chk("rst_addr",    im_addr_o, 0);
    chk("rst_err",     err_o, 0);
    wlog.delete();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    ld_valid_i = 1'b1;
    ld_data_i  = d;
    ld_last_i  = last;
    @(posedge clk_i);
    #1;
    ld_valid_i = 1'b0;
    ld_data_i  = $urandom;
    ld_last_i  = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (!done_o && i < budget) begin
      @(negedge clk_i);
      i++;
    end
    chk("done_reached", done_o, 1);
  endtask

  task automatic chk_log(input string name, input int idx, input logic [31:0] a, input logic [31:0] d);
    if (idx < wlog.size()) chk(name, wlog[idx], {a, d});
    else chk({name, "_missing"}, 64'(wlog.size()), 64'(idx + 1));
  endtask

  logic [31:0] prog3 [3] = '{32'h20080005, 32'h20090007, 32'h01095020};

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // Three words back-to-back.
    for (int i = 0; i < 3; i++) send_word(prog3[i], i == 2);
    wait_done(10);
    chk("t1_cnt", word_cnt_o, 3);
    chk("t1_model_n", 64'(m_n), 3);
    chk("t1_nlog", 64'(wlog.size()), 3);
    for (int i = 0; i < 3; i++) chk_log("t1_wr", i, 32'(i * 4), prog3[i]);
    chk("t1_release_edge", 64'(m_last_edge), 3);

    // Same program with two-cycle bubbles between words.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send_word(prog3[i], i == 2);
      if (i < 2) idle(2);
    end
    wait_done(10);
    chk("t2_nlog", 64'(wlog.size()), 3);
    for (int i = 0; i < 3; i++) chk_log("t2_wr", i, 32'(i * 4), prog3[i]);

    // Full-depth program, then extra words that must be refused.
    do_reset();
    for (int i = 0; i < DEPTH; i++) send_word(32'hA000_0000 + 32'(i), i == DEPTH - 1);
    wait_done(10);
    for (int i = 0; i < 3; i++) send_word(32'hDEAD_0000 + 32'(i), 1'b0);
    idle(2);
    chk("t3_cnt", word_cnt_o, 32);
    chk("t3_err", err_o, 0);
    chk("t3_nlog", 64'(wlog.size()), 32);
    chk_log("t3_final", DEPTH - 1, 32'd124, 32'hA000_001F);

    // Overflow: 33 words, none marked last.
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) send_word(32'hB000_0000 + 32'(i), 1'b0);
    idle(3);
    chk("t4_err", err_o, 1);
    chk("t4_cpu_rst", cpu_rst_o, 0);
    chk("t4_ready", ld_ready_o, 0);
    chk("t4_nlog", 64'(wlog.size()), 32);
    chk("t4_model_err", 64'(m_err), 1);
    chk_log("t4_final", DEPTH - 1, 32'd124, 32'hB000_001F);

    // Reset in the middle of a write, then reload.
    do_reset();
    send_word(32'hC000_0000, 1'b0);
    send_word(32'hC000_0001, 1'b0);
    chk("t5_we_before", im_we_o, 1);
    do_reset();
    for (int i = 0; i < 4; i++) send_word(32'hC100_0000 + 32'(i), i == 3);
    wait_done(10);
    chk("t5_nlog", 64'(wlog.size()), 4);
    for (int i = 0; i < 4; i++) chk_log("t5_wr", i, 32'(i * 4), 32'hC100_0000 + 32'(i));

    // One-word program: release exactly three edges after acceptance.
    do_reset();
    send_word(32'h1234_5678, 1'b1);
    @(negedge clk_i);
    chk("t6_rel_0", cpu_rst_o, 0);
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      chk("t6_rel", cpu_rst_o, (e == 3) ? 64'd1 : 64'd0);
    end
    chk("t6_nlog", 64'(wlog.size()), 1);
    chk_log("t6_wr", 0, 32'd0, 32'h1234_5678);
    chk("t6_cnt", word_cnt_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
